// File: rtl/el2_dccm_scrub.sv
// el2_dccm_scrub: background DCCM ECC scrubber that reads, checks and rewrites corrected words
module el2_dccm_scrub #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int INTV_W           = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scrub_en,
  input  logic [INTV_W-1:0]           scrub_interval,
  input  logic                        core_busy,
  input  logic                        core_wren,
  input  logic [DCCM_BITS-1:0]        core_wr_addr,
  output logic                        dccm_rden,
  output logic                        dccm_wren,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data,
  input  logic                        dec_single_err,
  input  logic                        dec_double_err,
  input  logic [DCCM_FDATA_WIDTH-1:0] dec_corr_data,
  output logic [15:0]                 scrub_sb_cnt,
  output logic                        scrub_db_err,
  output logic [DCCM_BITS-1:0]        scrub_db_addr,
  output logic                        scrub_pass_done
);
  typedef enum logic [1:0] {IDLE, RD, CHK, WR} state_t;
  state_t state, state_nx;
  logic [INTV_W-1:0] cnt;
  logic [DCCM_BITS-1:0] scrub_addr;
  logic hit, adv, inc, wrap;
  // A core write to the word being scrubbed makes our corrected copy stale
  assign hit  = core_wren && (core_wr_addr[DCCM_BITS-1:2] == scrub_addr[DCCM_BITS-1:2]);
  assign wrap = &scrub_addr[DCCM_BITS-1:2];
  assign dccm_rd_addr = scrub_addr;
  assign dccm_wr_addr = scrub_addr;
  // Next state and DCCM strobes; strobes only fire when the core leaves the port free
  always_comb begin
    state_nx  = state;
    adv       = 1'b0;
    inc       = 1'b0;
    dccm_rden = 1'b0;
    dccm_wren = 1'b0;
    case (state)
      IDLE: if (scrub_en && cnt == '0) state_nx = RD;
      RD: begin
        if (!scrub_en) state_nx = IDLE;
        else if (!core_busy) begin
          dccm_rden = 1'b1;
          state_nx  = CHK;
        end
      end
      CHK: begin
        if (dec_single_err && !dec_double_err && !hit) state_nx = WR;
        else adv = 1'b1;
      end
      WR: begin
        if (hit) adv = 1'b1;
        else if (!core_busy) begin
          dccm_wren = 1'b1;
          inc       = 1'b1;
          adv       = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (adv) state_nx = IDLE;
  end
  // State, interval timer, scrub pointer and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      scrub_addr      <= '0;
      scrub_sb_cnt    <= '0;
      scrub_db_err    <= 1'b0;
      scrub_db_addr   <= '0;
      scrub_pass_done <= 1'b0;
      dccm_wr_data    <= '0;
    end else begin
      state           <= state_nx;
      cnt             <= (state != IDLE && state_nx == IDLE) ? scrub_interval :
                         (state == IDLE && scrub_en && cnt != '0) ? cnt - INTV_W'(1) : cnt;
      scrub_pass_done <= adv && wrap;
      scrub_db_err    <= state == CHK && dec_double_err;
      if (adv) scrub_addr <= scrub_addr + DCCM_BITS'(4);
      if (state == CHK && dec_double_err) scrub_db_addr <= scrub_addr;
      if (state == CHK && dec_single_err && !dec_double_err) dccm_wr_data <= dec_corr_data;
      if (inc && scrub_sb_cnt != 16'hFFFF) scrub_sb_cnt <= scrub_sb_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_el2_dccm_scrub.sv
// tb_el2_dccm_scrub: directed self-checking bench for the DCCM scrubber
module tb_el2_dccm_scrub;
  logic        clk = 1'b0;
  logic        rst;
  logic        scrub_en;
  logic [15:0] scrub_interval;
  logic        core_busy;
  logic        core_wren;
  logic [15:0] core_wr_addr;
  logic        dccm_rden, dccm_wren;
  logic [15:0] dccm_rd_addr, dccm_wr_addr;
  logic [38:0] dccm_wr_data;
  logic        dec_single_err, dec_double_err;
  logic [38:0] dec_corr_data;
  logic [15:0] scrub_sb_cnt;
  logic        scrub_db_err;
  logic [15:0] scrub_db_addr;
  logic        scrub_pass_done;

  int asserts = 0;
  int fails = 0;
  int wren_cnt = 0;
  int bad = 0;
  logic [15:0] last_rd = '0;
  logic        se_on = 1'b0, se_all = 1'b0, db_on = 1'b0;
  logic [15:0] se_addr = '0, db_addr = '0;

  el2_dccm_scrub dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en), .scrub_interval(scrub_interval),
    .core_busy(core_busy), .core_wren(core_wren), .core_wr_addr(core_wr_addr),
    .dccm_rden(dccm_rden), .dccm_wren(dccm_wren), .dccm_rd_addr(dccm_rd_addr),
    .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
    .dec_single_err(dec_single_err), .dec_double_err(dec_double_err),
    .dec_corr_data(dec_corr_data), .scrub_sb_cnt(scrub_sb_cnt),
    .scrub_db_err(scrub_db_err), .scrub_db_addr(scrub_db_addr),
    .scrub_pass_done(scrub_pass_done)
  );

  always #5 clk = ~clk;

  function automatic logic [38:0] corr(input logic [15:0] a);
    return {7'h5A, 16'hC3A5, a};
  endfunction

  // Decoder model: flags and corrected data appear the cycle after a read
  always @(posedge clk) begin
    dec_single_err <= 1'b0;
    dec_double_err <= 1'b0;
    dec_corr_data  <= '0;
    if (dccm_rden) begin
      dec_single_err <= se_all || (se_on && dccm_rd_addr == se_addr);
      dec_double_err <= db_on && dccm_rd_addr == db_addr;
      dec_corr_data  <= corr(dccm_rd_addr);
    end
  end

  // Strobe monitor: counts writes and flags illegal strobe combinations
  always @(negedge clk) begin
    if (!rst) begin
      if (dccm_wren) wren_cnt++;
      if (dccm_rden) last_rd = dccm_rd_addr;
      if ((dccm_rden && dccm_wren) || ((dccm_rden || dccm_wren) && core_busy)) bad++;
    end
  end

  task automatic wait_rden(input int lim, output int n, output logic [15:0] a, output bit ok);
    n = 0; ok = 1'b0; a = '0;
    while (n < lim && !ok) begin
      @(negedge clk);
      n++;
      if (dccm_rden) begin ok = 1'b1; a = dccm_rd_addr; end
    end
  endtask

  task automatic wait_rd_at(input logic [15:0] t, output bit ok);
    int n; logic [15:0] a; bit got;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      wait_rden(40, n, a, got);
      if (got && a == t) ok = 1'b1;
    end
  endtask

  task automatic wait_wren(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (dccm_wren) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; scrub_en = 1'b0; scrub_interval = 16'd3;
    core_busy = 1'b0; core_wren = 1'b0; core_wr_addr = '0;
    repeat (3) @(negedge clk);
    asserts++;
    if ({dccm_rden, dccm_wren, scrub_db_err, scrub_pass_done} !== 4'b0) begin
      fails++; $display("FAIL reset_strobes got %b want 0000", {dccm_rden, dccm_wren, scrub_db_err, scrub_pass_done});
    end
    asserts++;
    if (dccm_rd_addr !== 16'h0 || scrub_db_addr !== 16'h0) begin
      fails++; $display("FAIL reset_addr got rd=%h db=%h want 0", dccm_rd_addr, scrub_db_addr);
    end
    asserts++;
    if (scrub_sb_cnt !== 16'h0 || dccm_wr_data !== 39'h0) begin
      fails++; $display("FAIL reset_cnt_data got cnt=%h data=%h want 0", scrub_sb_cnt, dccm_wr_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_reads;
    int n; logic [15:0] a; bit ok;
    scrub_en = 1'b1;
    wait_rden(20, n, a, ok);
    asserts++;
    if (!ok || a !== 16'h0) begin fails++; $display("FAIL read0 got ok=%0d addr=%h want 0000", ok, a); end
    wait_rden(20, n, a, ok);
    asserts++;
    if (!ok || a !== 16'h4 || n != 6) begin fails++; $display("FAIL read4 got addr=%h gap=%0d want 0004 gap 6", a, n); end
    wait_rden(20, n, a, ok);
    asserts++;
    if (!ok || a !== 16'h8 || n != 6) begin fails++; $display("FAIL read8 got addr=%h gap=%0d want 0008 gap 6", a, n); end
    asserts++;
    if (wren_cnt != 0) begin fails++; $display("FAIL clean_no_wren got %0d want 0", wren_cnt); end
  endtask

  task automatic test_single_err;
    bit ok;
    se_addr = 16'h10; se_on = 1'b1;
    wait_rd_at(16'h10, ok);
    wait_wren(10, ok);
    asserts++;
    if (!ok || dccm_wr_addr !== 16'h10 || dccm_wr_data !== corr(16'h10)) begin
      fails++; $display("FAIL sb_write got ok=%0d addr=%h data=%h want 0010 %h", ok, dccm_wr_addr, dccm_wr_data, corr(16'h10));
    end
    @(negedge clk);
    se_on = 1'b0;
    asserts++;
    if (scrub_sb_cnt !== 16'd1 || dccm_wren !== 1'b0) begin
      fails++; $display("FAIL sb_count got cnt=%h wren=%b want 0001 0", scrub_sb_cnt, dccm_wren);
    end
    asserts++;
    if (wren_cnt != 1) begin fails++; $display("FAIL sb_wren_count got %0d want 1", wren_cnt); end
  endtask

  task automatic test_double_err;
    int w0; bit seen;
    db_addr = 16'h20; db_on = 1'b1; w0 = wren_cnt; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (scrub_db_err) seen = 1'b1;
    end
    db_on = 1'b0;
    asserts++;
    if (!seen || scrub_db_addr !== 16'h20) begin fails++; $display("FAIL db_pulse got seen=%0d addr=%h want 1 0020", seen, scrub_db_addr); end
    @(negedge clk);
    asserts++;
    if (scrub_db_err !== 1'b0) begin fails++; $display("FAIL db_width got %b want 0", scrub_db_err); end
    asserts++;
    if (wren_cnt != w0 || scrub_sb_cnt !== 16'd1) begin
      fails++; $display("FAIL db_nowrite got wrens=%0d cnt=%h want %0d 0001", wren_cnt, scrub_sb_cnt, w0);
    end
  endtask

  task automatic test_abort;
    int w0, n; logic [15:0] a; bit ok;
    se_addr = 16'h30; se_on = 1'b1; w0 = wren_cnt;
    wait_rd_at(16'h30, ok);
    asserts++;
    if (!ok) begin fails++; $display("FAIL abort_read got none want read at 0030"); end
    @(negedge clk);
    core_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      core_wren = (i == 1);
      core_wr_addr = 16'h32;
    end
    @(negedge clk);
    core_busy = 1'b0; core_wren = 1'b0; se_on = 1'b0;
    wait_rden(20, n, a, ok);
    asserts++;
    if (!ok || a !== 16'h34) begin fails++; $display("FAIL abort_next got addr=%h want 0034", a); end
    asserts++;
    if (wren_cnt != w0 || scrub_sb_cnt !== 16'd1) begin
      fails++; $display("FAIL abort_nowrite got wrens=%0d cnt=%h want %0d 0001", wren_cnt, scrub_sb_cnt, w0);
    end
    asserts++;
    if (bad != 0) begin fails++; $display("FAIL strobe_rules got %0d violations want 0", bad); end
  endtask

  task automatic test_pass_done;
    bit seen;
    scrub_interval = 16'd0; seen = 1'b0;
    for (int i = 0; i < 60000 && !seen; i++) begin
      @(negedge clk);
      if (scrub_pass_done) seen = 1'b1;
    end
    asserts++;
    if (!seen || last_rd !== 16'hFFFC) begin fails++; $display("FAIL pass_done got seen=%0d last=%h want 1 fffc", seen, last_rd); end
    @(negedge clk);
    asserts++;
    if (scrub_pass_done !== 1'b0 || dccm_rden !== 1'b1 || dccm_rd_addr !== 16'h0) begin
      fails++; $display("FAIL pass_wrap got pd=%b rden=%b addr=%h want 0 1 0000", scrub_pass_done, dccm_rden, dccm_rd_addr);
    end
  endtask

  task automatic test_reset_in_wr;
    int n; logic [15:0] a; bit ok;
    se_all = 1'b1;
    wait_rden(20, n, a, ok);
    @(negedge clk);
    core_busy = 1'b1;
    @(negedge clk);
    asserts++;
    if (dccm_wren !== 1'b0) begin fails++; $display("FAIL wr_stall got wren=%b want 0", dccm_wren); end
    rst = 1'b1;
    #1;
    asserts++;
    if ({dccm_rden, dccm_wren, scrub_db_err, scrub_pass_done} !== 4'b0 || dccm_rd_addr !== 16'h0) begin
      fails++; $display("FAIL rst_wr_strobes got %b addr=%h want 0000 0000", {dccm_rden, dccm_wren, scrub_db_err, scrub_pass_done}, dccm_rd_addr);
    end
    asserts++;
    if (scrub_sb_cnt !== 16'h0 || scrub_db_addr !== 16'h0 || dccm_wr_data !== 39'h0) begin
      fails++; $display("FAIL rst_wr_regs got cnt=%h db=%h data=%h want 0", scrub_sb_cnt, scrub_db_addr, dccm_wr_data);
    end
    @(negedge clk);
    core_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_rden(20, n, a, ok);
    asserts++;
    if (!ok || a !== 16'h0) begin fails++; $display("FAIL rst_restart got addr=%h want 0000", a); end
    wait_wren(10, ok);
    se_all = 1'b0;
    @(negedge clk);
    asserts++;
    if (!ok || scrub_sb_cnt !== 16'd1) begin fails++; $display("FAIL rst_rewrite got ok=%0d cnt=%h want 1 0001", ok, scrub_sb_cnt); end
  endtask

  task automatic test_saturation;
    bit ok;
    repeat (4) @(negedge clk);
    force dut.scrub_sb_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.scrub_sb_cnt;
    se_all = 1'b1;
    wait_wren(20, ok);
    @(negedge clk);
    asserts++;
    if (!ok || scrub_sb_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_reach got ok=%0d cnt=%h want 1 ffff", ok, scrub_sb_cnt); end
    wait_wren(20, ok);
    @(negedge clk);
    se_all = 1'b0;
    asserts++;
    if (!ok || scrub_sb_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_hold got ok=%0d cnt=%h want 1 ffff", ok, scrub_sb_cnt); end
  endtask

  initial begin
    test_reset;
    test_clean_reads;
    test_single_err;
    test_double_err;
    test_abort;
    test_pass_done;
    test_reset_in_wr;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
